// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C transfer sequencer.
//   seq_state_e : sequencer FSM states
//   eng_cmd_e   : bit-engine command encodings
//   CFG_*       : CFG_REG field offsets/widths
package i2c_seq_pkg;

    localparam int DATA_W       = 8;
    localparam int CNT_W        = 5;
    localparam int TMO_W        = 14;
    localparam int CFG_W        = 14;

    localparam int CFG_START    = 0;
    localparam int CFG_RW       = 1;
    localparam int CFG_ADDR_LSB = 2;
    localparam int CFG_ADDR_W   = 7;
    localparam int CFG_CNT_LSB  = 9;

    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_STOP  = 2'b11
    } eng_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_WR_DATA,
        S_RD_DATA,
        S_STOP,
        S_ERR
    } seq_state_e;

endpackage

// File: rtl/i2c_seq_timeout.sv
// Saturating cycle counter for one outstanding engine command or FIFO stall.
//   PCLK/PRESET : clock, synchronous active-high reset
//   clr         : zero the counter (takes priority over en)
//   en          : count this cycle
//   limit       : expiry threshold, 0 disables
//   expired     : high during the limit-th consecutive enabled cycle
module i2c_seq_timeout
    import i2c_seq_pkg::*;
#(
    parameter int W = TMO_W
) (
    input  logic         PCLK,
    input  logic         PRESET,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge PCLK) begin
        if (PRESET || clr)
            cnt <= '0;
        else if (en && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

    // cnt holds the number of enabled cycles before this one, so the
    // limit-th enabled cycle sees cnt == limit-1. The limit is compared
    // live, so lowering it mid-wait can expire at once.
    assign expired = en && (limit != '0) && (cnt >= limit - 1'b1);

endmodule

// File: rtl/i2c_transfer_sequencer.sv
// Byte-level I2C master sequencer: START, address, N data bytes, STOP.
//   CFG_REG/TIMEOUT_REG        : front-end config (start edge, rw, addr, count) and timeout
//   TX_FIFO_*                  : FWFT write-data source, one-cycle pops
//   RX_FIFO_*                  : read-data sink, one-cycle pushes
//   ENG_*                      : valid/done handshake with the I2C bit engine
//   BUSY/DONE/ERROR            : status to the front end
module i2c_transfer_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int DATA_W = i2c_seq_pkg::DATA_W,
    parameter int CNT_W  = i2c_seq_pkg::CNT_W
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [CFG_W-1:0]  CFG_REG,
    input  logic [TMO_W-1:0]  TIMEOUT_REG,
    input  logic              TX_FIFO_EMPTY,
    input  logic [DATA_W-1:0] TX_FIFO_DATA,
    output logic              TX_FIFO_RD,
    input  logic              RX_FIFO_FULL,
    output logic              RX_FIFO_WR,
    output logic [DATA_W-1:0] RX_FIFO_DATA,
    output logic [1:0]        ENG_CMD,
    output logic              ENG_CMD_VALID,
    output logic [DATA_W-1:0] ENG_WDATA,
    output logic              ENG_NACK,
    input  logic              ENG_CMD_DONE,
    input  logic [DATA_W-1:0] ENG_RDATA,
    input  logic              ENG_ACK_IN,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERROR
);

    seq_state_e              state;
    eng_cmd_e                cmd_q;
    logic                    start_q, rw_q, err_path, rx_pend;
    logic [CFG_ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    tmo_en, tmo_expired, start_edge;

    assign start_edge = CFG_REG[CFG_START] & ~start_q;
    assign ENG_CMD    = cmd_q;

    // Time runs while a command is outstanding or while waiting on a FIFO.
    // The single idle cycle between commands (and the pop/push cycle that
    // ends a stall) clears the counter, giving each wait a fresh budget.
    assign tmo_en = ENG_CMD_VALID
                  | ((state == S_WR_DATA) & ~ENG_CMD_VALID & TX_FIFO_EMPTY)
                  | ((state == S_RD_DATA) & rx_pend & RX_FIFO_FULL);

    i2c_seq_timeout #(.W(TMO_W)) u_timeout (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .clr     (~tmo_en),
        .en      (tmo_en),
        .limit   (TIMEOUT_REG),
        .expired (tmo_expired)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state         <= S_IDLE;
            cmd_q         <= CMD_START;
            start_q       <= 1'b0;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            cnt_q         <= '0;
            err_path      <= 1'b0;
            rx_pend       <= 1'b0;
            ENG_CMD_VALID <= 1'b0;
            ENG_WDATA     <= '0;
            ENG_NACK      <= 1'b0;
            TX_FIFO_RD    <= 1'b0;
            RX_FIFO_WR    <= 1'b0;
            RX_FIFO_DATA  <= '0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            ERROR         <= 1'b0;
        end else begin
            start_q    <= CFG_REG[CFG_START];
            DONE       <= 1'b0;
            TX_FIFO_RD <= 1'b0;
            RX_FIFO_WR <= 1'b0;

            if (tmo_expired) begin
                // A timeout while already stopping after an error gives up
                // on the bus; otherwise try to release it with a STOP.
                ENG_CMD_VALID <= 1'b0;
                rx_pend       <= 1'b0;
                if (err_path) begin
                    state <= S_ERR;
                    BUSY  <= 1'b0;
                end else begin
                    ERROR    <= 1'b1;
                    err_path <= 1'b1;
                    state    <= S_STOP;
                end
            end else begin
                case (state)
                    S_IDLE, S_ERR: begin
                        if (start_edge) begin
                            rw_q     <= CFG_REG[CFG_RW];
                            addr_q   <= CFG_REG[CFG_ADDR_LSB +: CFG_ADDR_W];
                            cnt_q    <= CFG_REG[CFG_CNT_LSB +: CNT_W];
                            ERROR    <= 1'b0;
                            err_path <= 1'b0;
                            BUSY     <= 1'b1;
                            state    <= S_START;
                        end
                    end
                    S_START: begin
                        if (!ENG_CMD_VALID) begin
                            ENG_CMD_VALID <= 1'b1;
                            cmd_q         <= CMD_START;
                            ENG_NACK      <= 1'b0;
                        end else if (ENG_CMD_DONE) begin
                            ENG_CMD_VALID <= 1'b0;
                            state         <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        if (!ENG_CMD_VALID) begin
                            ENG_CMD_VALID <= 1'b1;
                            cmd_q         <= CMD_WRITE;
                            ENG_WDATA     <= {addr_q, rw_q};
                            ENG_NACK      <= 1'b0;
                        end else if (ENG_CMD_DONE) begin
                            ENG_CMD_VALID <= 1'b0;
                            if (ENG_ACK_IN) begin
                                ERROR    <= 1'b1;
                                err_path <= 1'b1;
                                state    <= S_STOP;
                            end else if (cnt_q == '0)
                                state <= S_STOP;
                            else if (rw_q)
                                state <= S_RD_DATA;
                            else
                                state <= S_WR_DATA;
                        end
                    end
                    S_WR_DATA: begin
                        if (!ENG_CMD_VALID) begin
                            // FWFT head is valid now; pop and capture together.
                            if (!TX_FIFO_EMPTY) begin
                                TX_FIFO_RD    <= 1'b1;
                                ENG_WDATA     <= TX_FIFO_DATA;
                                ENG_CMD_VALID <= 1'b1;
                                cmd_q         <= CMD_WRITE;
                                ENG_NACK      <= 1'b0;
                            end
                        end else if (ENG_CMD_DONE) begin
                            ENG_CMD_VALID <= 1'b0;
                            if (ENG_ACK_IN) begin
                                ERROR    <= 1'b1;
                                err_path <= 1'b1;
                                state    <= S_STOP;
                            end else begin
                                cnt_q <= cnt_q - 1'b1;
                                if (cnt_q == CNT_W'(1))
                                    state <= S_STOP;
                            end
                        end
                    end
                    S_RD_DATA: begin
                        // A received byte must reach the RX FIFO before the
                        // next READ goes out.
                        if (rx_pend) begin
                            if (!RX_FIFO_FULL) begin
                                RX_FIFO_WR <= 1'b1;
                                rx_pend    <= 1'b0;
                                cnt_q      <= cnt_q - 1'b1;
                                if (cnt_q == CNT_W'(1))
                                    state <= S_STOP;
                            end
                        end else if (!ENG_CMD_VALID) begin
                            ENG_CMD_VALID <= 1'b1;
                            cmd_q         <= CMD_READ;
                            ENG_NACK      <= (cnt_q == CNT_W'(1));
                        end else if (ENG_CMD_DONE) begin
                            ENG_CMD_VALID <= 1'b0;
                            RX_FIFO_DATA  <= ENG_RDATA;
                            rx_pend       <= 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (!ENG_CMD_VALID) begin
                            ENG_CMD_VALID <= 1'b1;
                            cmd_q         <= CMD_STOP;
                            ENG_NACK      <= 1'b0;
                        end else if (ENG_CMD_DONE) begin
                            ENG_CMD_VALID <= 1'b0;
                            BUSY          <= 1'b0;
                            if (err_path)
                                state <= S_ERR;
                            else begin
                                state <= S_IDLE;
                                DONE  <= 1'b1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_transfer_sequencer.sv
module tb_i2c_transfer_sequencer;
    import i2c_seq_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [13:0] CFG_REG = '0;
    logic [13:0] TIMEOUT_REG = '0;
    logic        TX_FIFO_EMPTY;
    logic [7:0]  TX_FIFO_DATA;
    logic        TX_FIFO_RD;
    logic        RX_FIFO_FULL = 1'b0;
    logic        RX_FIFO_WR;
    logic [7:0]  RX_FIFO_DATA;
    logic [1:0]  ENG_CMD;
    logic        ENG_CMD_VALID;
    logic [7:0]  ENG_WDATA;
    logic        ENG_NACK;
    logic        ENG_CMD_DONE;
    logic [7:0]  ENG_RDATA;
    logic        ENG_ACK_IN;
    logic        BUSY, DONE, ERROR;

    int checks = 0;
    int errors = 0;

    i2c_transfer_sequencer dut (
        .PCLK(PCLK), .PRESET(PRESET), .CFG_REG(CFG_REG), .TIMEOUT_REG(TIMEOUT_REG),
        .TX_FIFO_EMPTY(TX_FIFO_EMPTY), .TX_FIFO_DATA(TX_FIFO_DATA), .TX_FIFO_RD(TX_FIFO_RD),
        .RX_FIFO_FULL(RX_FIFO_FULL), .RX_FIFO_WR(RX_FIFO_WR), .RX_FIFO_DATA(RX_FIFO_DATA),
        .ENG_CMD(ENG_CMD), .ENG_CMD_VALID(ENG_CMD_VALID), .ENG_WDATA(ENG_WDATA),
        .ENG_NACK(ENG_NACK), .ENG_CMD_DONE(ENG_CMD_DONE), .ENG_RDATA(ENG_RDATA),
        .ENG_ACK_IN(ENG_ACK_IN), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
    );

    always #5 PCLK = ~PCLK;

    // TX FIFO model: tasks append bytes by moving tx_len, DUT pops move tx_head.
    logic [7:0] tx_mem [0:255];
    logic [7:0] tx_head = '0;
    logic [7:0] tx_len  = '0;
    assign TX_FIFO_EMPTY = (tx_head == tx_len);
    assign TX_FIFO_DATA  = tx_mem[tx_head];
    always @(posedge PCLK) if (TX_FIFO_RD) tx_head <= tx_head + 8'd1;

    // RX FIFO sink and DONE pulse counter.
    logic [7:0] rx_q [$];
    int         done_cnt = 0;
    always @(posedge PCLK) begin
        if (RX_FIFO_WR) rx_q.push_back(RX_FIFO_DATA);
        if (DONE) done_cnt <= done_cnt + 1;
    end

    // Bit-engine model: completes each command 3 cycles after VALID, logs
    // {cmd, nack, wdata}, NACKs the WRITE whose index equals nack_at, and can
    // be told to never complete one command type.
    int          dly = 0;
    int          wr_idx = 0;
    int          nack_at = -1;
    logic        hang_en = 1'b0;
    logic [1:0]  hang_cmd = 2'b00;
    logic [5:0]  rd_idx = '0;
    logic [7:0]  rd_bytes [0:63];
    logic [10:0] log_q [$];

    always @(posedge PCLK) begin
        ENG_CMD_DONE <= 1'b0;
        if (PRESET) begin
            dly        <= 0;
            ENG_ACK_IN <= 1'b0;
            ENG_RDATA  <= '0;
        end else if (!ENG_CMD_VALID) begin
            dly <= 0;
        end else if (!ENG_CMD_DONE && !(hang_en && ENG_CMD == hang_cmd)) begin
            if (dly == 2) begin
                dly          <= 0;
                ENG_CMD_DONE <= 1'b1;
                log_q.push_back({ENG_CMD, ENG_NACK, ENG_WDATA});
                if (ENG_CMD == CMD_WRITE) begin
                    ENG_ACK_IN <= (wr_idx == nack_at);
                    wr_idx     <= wr_idx + 1;
                end else begin
                    ENG_ACK_IN <= 1'b0;
                end
                if (ENG_CMD == CMD_READ) begin
                    ENG_RDATA <= rd_bytes[rd_idx];
                    rd_idx    <= rd_idx + 6'd1;
                end
            end else begin
                dly <= dly + 1;
            end
        end
    end

    int         lb, rb, db;
    logic [7:0] pb;

    function automatic logic [13:0] mk_cfg(input logic [4:0] cnt, input logic [6:0] addr, input logic rw);
        return {cnt, addr, rw, 1'b0};
    endfunction

    function automatic logic [10:0] ent(input logic [1:0] cmd, input logic nack, input logic [7:0] wd);
        return {cmd, nack, wd};
    endfunction

    // Write data only matters for WRITE commands.
    function automatic bit entry_match(input logic [10:0] got, input logic [10:0] exp);
        if (got[10:8] !== exp[10:8]) return 1'b0;
        if (exp[10:9] == CMD_WRITE && got[7:0] !== exp[7:0]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic start_xfer(input logic [13:0] cfg);
        lb = log_q.size(); rb = rx_q.size(); pb = tx_head; db = done_cnt;
        @(negedge PCLK) CFG_REG = cfg;
        @(negedge PCLK) CFG_REG = cfg | 14'd1;
        @(negedge PCLK) CFG_REG = cfg;
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge PCLK);
            if (!BUSY) begin to = 1'b0; break; end
        end
        @(negedge PCLK);
        @(negedge PCLK);
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        checks++; if (BUSY !== 1'b0)          begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
        checks++; if (DONE !== 1'b0)          begin errors++; $display("FAIL reset_done got %b exp 0", DONE); end
        checks++; if (ERROR !== 1'b0)         begin errors++; $display("FAIL reset_error got %b exp 0", ERROR); end
        checks++; if (ENG_CMD_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ENG_CMD_VALID); end
        checks++; if (TX_FIFO_RD !== 1'b0)    begin errors++; $display("FAIL reset_txrd got %b exp 0", TX_FIFO_RD); end
        checks++; if (RX_FIFO_WR !== 1'b0)    begin errors++; $display("FAIL reset_rxwr got %b exp 0", RX_FIFO_WR); end
        PRESET = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic test_write2();
        bit to;
        logic [10:0] exp [5];
        exp = '{ent(CMD_START,0,8'h00), ent(CMD_WRITE,0,8'hA0), ent(CMD_WRITE,0,8'hA5),
                ent(CMD_WRITE,0,8'h3C), ent(CMD_STOP,0,8'h00)};
        tx_mem[tx_head] = 8'hA5; tx_mem[tx_head + 8'd1] = 8'h3C; tx_len = tx_head + 8'd2;
        start_xfer(mk_cfg(5'd2, 7'h50, 1'b0));
        wait_idle(to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL write2_idle got busy exp idle"); end
        checks++;
        if (log_q.size() - lb !== 5) begin errors++; $display("FAIL write2_ncmd got %0d exp 5", log_q.size() - lb); end
        else for (int i = 0; i < 5; i++) begin
            checks++;
            if (!entry_match(log_q[lb+i], exp[i])) begin errors++; $display("FAIL write2_cmd[%0d] got %h exp %h", i, log_q[lb+i], exp[i]); end
        end
        checks++; if (tx_head - pb !== 8'd2)  begin errors++; $display("FAIL write2_pops got %0d exp 2", tx_head - pb); end
        checks++; if (done_cnt - db !== 1)    begin errors++; $display("FAIL write2_done got %0d exp 1", done_cnt - db); end
        checks++; if (ERROR !== 1'b0)         begin errors++; $display("FAIL write2_error got %b exp 0", ERROR); end
    endtask

    task automatic test_read3();
        bit to;
        logic [10:0] exp [6];
        logic [7:0]  rexp [3];
        exp = '{ent(CMD_START,0,8'h00), ent(CMD_WRITE,0,8'h43), ent(CMD_READ,0,8'h00),
                ent(CMD_READ,0,8'h00), ent(CMD_READ,1,8'h00), ent(CMD_STOP,0,8'h00)};
        rexp = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) rd_bytes[rd_idx + 6'(i)] = rexp[i];
        start_xfer(mk_cfg(5'd3, 7'h21, 1'b1));
        wait_idle(to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL read3_idle got busy exp idle"); end
        checks++;
        if (log_q.size() - lb !== 6) begin errors++; $display("FAIL read3_ncmd got %0d exp 6", log_q.size() - lb); end
        else for (int i = 0; i < 6; i++) begin
            checks++;
            if (!entry_match(log_q[lb+i], exp[i])) begin errors++; $display("FAIL read3_cmd[%0d] got %h exp %h", i, log_q[lb+i], exp[i]); end
        end
        checks++;
        if (rx_q.size() - rb !== 3) begin errors++; $display("FAIL read3_npush got %0d exp 3", rx_q.size() - rb); end
        else for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_q[rb+i] !== rexp[i]) begin errors++; $display("FAIL read3_rx[%0d] got %h exp %h", i, rx_q[rb+i], rexp[i]); end
        end
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL read3_done got %0d exp 1", done_cnt - db); end
    endtask

    task automatic test_addr_nack();
        bit to;
        logic [10:0] exp [3];
        exp = '{ent(CMD_START,0,8'h00), ent(CMD_WRITE,0,8'hA0), ent(CMD_STOP,0,8'h00)};
        nack_at = wr_idx;
        tx_mem[tx_head] = 8'h01; tx_mem[tx_head + 8'd1] = 8'h02; tx_len = tx_head + 8'd2;
        start_xfer(mk_cfg(5'd2, 7'h50, 1'b0));
        wait_idle(to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL nack_idle got busy exp idle"); end
        checks++;
        if (log_q.size() - lb !== 3) begin errors++; $display("FAIL nack_ncmd got %0d exp 3", log_q.size() - lb); end
        else for (int i = 0; i < 3; i++) begin
            checks++;
            if (!entry_match(log_q[lb+i], exp[i])) begin errors++; $display("FAIL nack_cmd[%0d] got %h exp %h", i, log_q[lb+i], exp[i]); end
        end
        checks++; if (ERROR !== 1'b1)         begin errors++; $display("FAIL nack_error got %b exp 1", ERROR); end
        checks++; if (done_cnt - db !== 0)    begin errors++; $display("FAIL nack_done got %0d exp 0", done_cnt - db); end
        checks++; if (tx_head - pb !== 8'd0)  begin errors++; $display("FAIL nack_pops got %0d exp 0", tx_head - pb); end
        nack_at = -1;
        tx_len = tx_head;
        // Address-only probe from ERR; the start edge clears ERROR.
        start_xfer(mk_cfg(5'd0, 7'h50, 1'b0));
        checks++; if (ERROR !== 1'b0) begin errors++; $display("FAIL nack_clear got %b exp 0", ERROR); end
        wait_idle(to);
        checks++; if (log_q.size() - lb !== 3) begin errors++; $display("FAIL probe_ncmd got %0d exp 3", log_q.size() - lb); end
        checks++; if (done_cnt - db !== 1)     begin errors++; $display("FAIL probe_done got %0d exp 1", done_cnt - db); end
    endtask

    task automatic test_timeout();
        bit to, seen;
        int n;
        TIMEOUT_REG = 14'd10; hang_en = 1'b1; hang_cmd = CMD_WRITE;
        start_xfer(mk_cfg(5'd1, 7'h50, 1'b0));
        n = 0; seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ERROR) begin seen = 1'b1; break; end
            if (ENG_CMD_VALID && ENG_CMD == CMD_WRITE) n++;
            @(negedge PCLK);
        end
        checks++; if (seen !== 1'b1)         begin errors++; $display("FAIL tmo_seen got 0 exp 1"); end
        checks++; if (n !== 10)              begin errors++; $display("FAIL tmo_cycles got %0d exp 10", n); end
        checks++; if (ENG_CMD_VALID !== 1'b0) begin errors++; $display("FAIL tmo_valid_drop got %b exp 0", ENG_CMD_VALID); end
        wait_idle(to);
        checks++;
        if (log_q.size() - lb !== 2 || !entry_match(log_q[lb+1], ent(CMD_STOP,0,8'h00))) begin
            errors++; $display("FAIL tmo_stop got %0d cmds exp START,STOP", log_q.size() - lb);
        end
        checks++; if (ERROR !== 1'b1)      begin errors++; $display("FAIL tmo_error got %b exp 1", ERROR); end
        checks++; if (done_cnt - db !== 0) begin errors++; $display("FAIL tmo_done got %0d exp 0", done_cnt - db); end
        // Disabled timeout: a hung command just waits.
        TIMEOUT_REG = 14'd0;
        start_xfer(mk_cfg(5'd1, 7'h50, 1'b0));
        repeat (1000) @(negedge PCLK);
        checks++; if (ERROR !== 1'b0) begin errors++; $display("FAIL tmo0_error got %b exp 0", ERROR); end
        checks++; if (!(ENG_CMD_VALID === 1'b1 && ENG_CMD === CMD_WRITE)) begin
            errors++; $display("FAIL tmo0_valid got %b/%b exp 1/01", ENG_CMD_VALID, ENG_CMD);
        end
        // Limit is compared live: lowering it below the elapsed count fires at once.
        TIMEOUT_REG = 14'd5; hang_en = 1'b0;
        wait_idle(to);
        checks++; if (ERROR !== 1'b1) begin errors++; $display("FAIL tmo_live got %b exp 1", ERROR); end
        TIMEOUT_REG = 14'd0;
    endtask

    task automatic test_tx_stall();
        bit to, bad, reached;
        tx_mem[tx_head] = 8'h77; tx_len = tx_head + 8'd1;
        start_xfer(mk_cfg(5'd2, 7'h50, 1'b0));
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (log_q.size() - lb == 3) begin reached = 1'b1; break; end
            @(negedge PCLK);
        end
        checks++; if (reached !== 1'b1) begin errors++; $display("FAIL txstall_reach got 0 exp 1"); end
        bad = 1'b0;
        repeat (5) begin @(negedge PCLK); if (ENG_CMD_VALID || TX_FIFO_RD) bad = 1'b1; end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL txstall_idle got activity exp none"); end
        tx_mem[tx_head] = 8'h88; tx_len = tx_head + 8'd1;
        wait_idle(to);
        checks++;
        if (log_q.size() - lb !== 5 || !entry_match(log_q[lb+3], ent(CMD_WRITE,0,8'h88))) begin
            errors++; $display("FAIL txstall_cmd got %0d cmds exp 5 with WRITE 88", log_q.size() - lb);
        end
        checks++; if (tx_head - pb !== 8'd2) begin errors++; $display("FAIL txstall_pops got %0d exp 2", tx_head - pb); end
        checks++; if (done_cnt - db !== 1)   begin errors++; $display("FAIL txstall_done got %0d exp 1", done_cnt - db); end
    endtask

    task automatic test_rx_stall();
        bit to, bad, reached;
        RX_FIFO_FULL = 1'b1;
        rd_bytes[rd_idx] = 8'h5A; rd_bytes[rd_idx + 6'd1] = 8'h6B;
        start_xfer(mk_cfg(5'd2, 7'h10, 1'b1));
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (log_q.size() - lb == 3) begin reached = 1'b1; break; end
            @(negedge PCLK);
        end
        checks++; if (reached !== 1'b1) begin errors++; $display("FAIL rxstall_reach got 0 exp 1"); end
        bad = 1'b0;
        repeat (5) begin @(negedge PCLK); if (ENG_CMD_VALID || RX_FIFO_WR) bad = 1'b1; end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rxstall_hold got activity exp none"); end
        RX_FIFO_FULL = 1'b0;
        wait_idle(to);
        checks++;
        if (rx_q.size() - rb !== 2 || rx_q[rb] !== 8'h5A || rx_q[rb+1] !== 8'h6B) begin
            errors++; $display("FAIL rxstall_data got %0d bytes exp 5A,6B", rx_q.size() - rb);
        end
        checks++;
        if (log_q.size() - lb !== 5 || !entry_match(log_q[lb+3], ent(CMD_READ,1,8'h00))) begin
            errors++; $display("FAIL rxstall_cmd got %0d cmds exp 5 with last READ nack", log_q.size() - lb);
        end
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL rxstall_done got %0d exp 1", done_cnt - db); end
    endtask

    task automatic test_reset_mid_read();
        bit to, reached;
        hang_en = 1'b1; hang_cmd = CMD_READ;
        start_xfer(mk_cfg(5'd2, 7'h21, 1'b1));
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ENG_CMD_VALID && ENG_CMD == CMD_READ) begin reached = 1'b1; break; end
            @(negedge PCLK);
        end
        checks++; if (reached !== 1'b1) begin errors++; $display("FAIL rstrd_reach got 0 exp 1"); end
        PRESET = 1'b1;
        @(negedge PCLK);
        checks++; if (BUSY !== 1'b0)          begin errors++; $display("FAIL rstrd_busy got %b exp 0", BUSY); end
        checks++; if (ENG_CMD_VALID !== 1'b0) begin errors++; $display("FAIL rstrd_valid got %b exp 0", ENG_CMD_VALID); end
        checks++; if (ERROR !== 1'b0)         begin errors++; $display("FAIL rstrd_error got %b exp 0", ERROR); end
        PRESET = 1'b0; hang_en = 1'b0;
        start_xfer(mk_cfg(5'd0, 7'h21, 1'b0));
        wait_idle(to);
        checks++;
        if (log_q.size() - lb !== 3 || !entry_match(log_q[lb+1], ent(CMD_WRITE,0,8'h42))) begin
            errors++; $display("FAIL rstrd_restart got %0d cmds exp START,WRITE 42,STOP", log_q.size() - lb);
        end
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL rstrd_done got %0d exp 1", done_cnt - db); end
    endtask

    initial begin
        test_reset();
        test_write2();
        test_read3();
        test_addr_nack();
        test_timeout();
        test_tx_stall();
        test_rx_stall();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
